// File: rtl/vga_sprite_src_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : vga_sprite_src_pkg                                             |
// | Purpose : Shared types and constants for the sprite pixel source         |
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
package vga_sprite_src_pkg;

  // Pixel word, packed as bbbb_gggg_rrrr
  typedef logic [11:0] pixel_t;

  localparam pixel_t     BG_COLOR  = 12'h0F8;
  localparam pixel_t     KEY_COLOR = 12'hF0F;
  localparam logic [8:0] LAST_ROW  = 9'd479;

  // Position update sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } pos_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sprite_src_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : spr_ram_16x16                                                  |
// | Purpose : 256x12 sprite bitmap, synchronous write / asynchronous read    |
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
module spr_ram_16x16
  import vga_sprite_src_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          vga_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t r_mem [0:(1<<AW)-1];

  // Write port: one word per cycle when enabled; contents are never reset
  always_ff @(posedge vga_clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/vga_sprite_src.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : vga_sprite_src                                                 |
// | Purpose : VGA read-side pixel source compositing one sprite over a flat  |
// |           background; position/bitmap updates only land in vblank.      |
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
module vga_sprite_src #(
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 16,
  parameter logic [11:0] BG_COLOR  = vga_sprite_src_pkg::BG_COLOR,
  parameter logic [11:0] KEY_COLOR = vga_sprite_src_pkg::KEY_COLOR,
  parameter logic [8:0]  LAST_ROW  = vga_sprite_src_pkg::LAST_ROW
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [11:0] d_in,
  input  logic [9:0]  pos_x,
  input  logic [8:0]  pos_y,
  input  logic        pos_flip,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [7:0]  bmp_addr,
  input  logic [11:0] bmp_data,
  input  logic        bmp_valid,
  output logic        bmp_ready,
  output logic        vblank,
  output logic [15:0] frame_cnt
);

  import vga_sprite_src_pkg::*;

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  // Frame boundary tracking
  logic        r_rdn_q;
  logic        r_vblank;
  logic        r_bmp_ready;
  logic [15:0] r_frame_cnt;
  logic        w_eof;
  logic        w_sof;
  logic        w_vblank_nxt;

  // Position sequencer
  pos_state_t  r_state;
  pos_state_t  w_next_state;
  logic        r_pos_ready;
  logic        w_accept;
  logic        w_apply;
  logic [9:0]  r_pend_x;
  logic [8:0]  r_pend_y;
  logic        r_pend_flip;
  logic [9:0]  r_act_x;
  logic [8:0]  r_act_y;
  logic        r_act_flip;

  // Pixel path
  logic [10:0]      w_dx;
  logic [10:0]      w_dy;
  logic             w_hit;
  logic [XW-1:0]    w_spr_col;
  logic [XW+YW-1:0] w_ram_raddr;
  pixel_t           w_ram_word;

  // End of frame: read strobe releases after the last visible row.
  // Start of frame: first read strobe while blanked.
  assign w_eof        = !r_rdn_q && rdn && (row_addr == LAST_ROW);
  assign w_sof        = r_rdn_q && !rdn && r_vblank;
  assign w_vblank_nxt = w_eof ? 1'b1 : (w_sof ? 1'b0 : r_vblank);

  // Blank flag, frame counter and bitmap-ready follow the read strobe edges
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_rdn_q     <= 1'b1;
      r_vblank    <= 1'b1;
      r_bmp_ready <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_rdn_q     <= rdn;
      r_vblank    <= w_vblank_nxt;
      r_bmp_ready <= w_vblank_nxt;
      if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Sequencer state register; ready is registered from the next state
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= IDLE;
      r_pos_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pos_ready <= (w_next_state == IDLE);
    end
  end

  // Sequencer next state: accept in IDLE, hold until blank, apply for one cycle
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_apply      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (pos_valid && r_pos_ready) begin
          w_accept     = 1'b1;
          w_next_state = PEND;
        end
      end
      PEND: begin
        if (r_vblank) w_next_state = APPLY;
      end
      APPLY: begin
        w_apply      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Pending request capture and active position update
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_pend_x    <= 10'd0;
      r_pend_y    <= 9'd0;
      r_pend_flip <= 1'b0;
      r_act_x     <= 10'd0;
      r_act_y     <= 9'd0;
      r_act_flip  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_x    <= pos_x;
        r_pend_y    <= pos_y;
        r_pend_flip <= pos_flip;
      end
      if (w_apply) begin
        r_act_x    <= r_pend_x;
        r_act_y    <= r_pend_y;
        r_act_flip <= r_pend_flip;
      end
    end
  end

  // Offsets from the sprite origin; pixels left/above wrap to large values and miss
  assign w_dx  = {1'b0, col_addr} - {1'b0, r_act_x};
  assign w_dy  = {2'b0, row_addr} - {2'b0, r_act_y};
  assign w_hit = (w_dx < 11'(SPR_W)) && (w_dy < 11'(SPR_H));

  // Mirroring: bitwise inversion equals SPR_W-1-dx because SPR_W is a power of 2
  assign w_spr_col   = r_act_flip ? ~w_dx[XW-1:0] : w_dx[XW-1:0];
  assign w_ram_raddr = {w_dy[YW-1:0], w_spr_col};

  spr_ram_16x16 #(
    .AW (XW + YW)
  ) u_ram (
    .vga_clk (vga_clk),
    .we      (bmp_valid && r_bmp_ready),
    .waddr   (bmp_addr),
    .wdata   (bmp_data),
    .raddr   (w_ram_raddr),
    .rdata   (w_ram_word)
  );

  // Zero-latency pixel mux: blank when not reading or held in reset
  always_comb begin
    d_in = 12'h000;
    if (clrn && !rdn) begin
      d_in = (w_hit && (w_ram_word != KEY_COLOR)) ? w_ram_word : BG_COLOR;
    end
  end

  assign pos_ready = r_pos_ready;
  assign bmp_ready = r_bmp_ready;
  assign vblank    = r_vblank;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_src.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : tb_vga_sprite_src                                              |
// | Purpose : Directed scoreboard bench for the sprite pixel source          |
// | Revision: 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
module tb_vga_sprite_src;

  logic        vga_clk;
  logic        clrn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [11:0] d_in;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        pos_flip;
  logic        pos_valid;
  logic        pos_ready;
  logic [7:0]  bmp_addr;
  logic [11:0] bmp_data;
  logic        bmp_valid;
  logic        bmp_ready;
  logic        vblank;
  logic [15:0] frame_cnt;

  vga_sprite_src dut (
    .vga_clk   (vga_clk),
    .clrn      (clrn),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .rdn       (rdn),
    .d_in      (d_in),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_flip  (pos_flip),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .bmp_addr  (bmp_addr),
    .bmp_data  (bmp_data),
    .bmp_valid (bmp_valid),
    .bmp_ready (bmp_ready),
    .vblank    (vblank),
    .frame_cnt (frame_cnt)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [11:0] m_ram [256];
  bit          m_known [256];
  int          m_x, m_y, p_x, p_y;
  bit          m_flip, p_flip;
  logic [15:0] m_frame;
  logic [11:0] sb_q [$];
  int          rows_q [$];
  int          cols_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pixel from the model; returns 0 when the sprite word is still unknown
  function automatic bit exp_px(input int r, input int c, output logic [11:0] v);
    int sc, a;
    v = 12'h0F8;
    if (c >= m_x && c < m_x + 16 && r >= m_y && r < m_y + 16) begin
      sc = m_flip ? 15 - (c - m_x) : (c - m_x);
      a  = (r - m_y) * 16 + sc;
      if (!m_known[a]) return 1'b0;
      if (m_ram[a] != 12'hF0F) v = m_ram[a];
    end
    return 1'b1;
  endfunction

  function automatic bit row_sel(input int r, input int st);
    if (r % st == 0 || r == 479) return 1'b1;
    foreach (rows_q[i]) if (rows_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit col_sel(input int c, input int st);
    if (c % st == 0) return 1'b1;
    foreach (cols_q[i]) if (cols_q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // One pixel-clock cycle as the VGA controller would drive it
  task automatic step(input int r, input int c, input bit rd, input string tag);
    logic [11:0] v;
    bit          known;
    row_addr = 9'(r);
    col_addr = 10'(c);
    rdn      = rd;
    if (rd) begin
      known = 1'b1;
      v     = 12'h000;
    end else begin
      known = exp_px(r, c, v);
    end
    if (known) sb_q.push_back(v);
    @(negedge vga_clk);
    if (known) chk($sformatf("%s r%0d c%0d", tag, r, c), 16'(d_in), 16'(sb_q.pop_front()));
    @(posedge vga_clk);
    #1;
  endtask

  // Position request made while blanked; ready must come back two cycles after acceptance
  task automatic req_pos(input int x, input int y, input bit f);
    chk("pos_rdy_idle", 16'(pos_ready), 16'd1);
    pos_x = 10'(x); pos_y = 9'(y); pos_flip = f; pos_valid = 1'b1;
    step(479, 0, 1'b1, "req");
    pos_valid = 1'b0;
    chk("pos_rdy_pend", 16'(pos_ready), 16'd0);
    step(479, 0, 1'b1, "req");
    chk("pos_rdy_apply", 16'(pos_ready), 16'd0);
    step(479, 0, 1'b1, "req");
    chk("pos_rdy_back", 16'(pos_ready), 16'd1);
    m_x = x; m_y = y; m_flip = f;
  endtask

  task automatic wr_bmp(input int a, input logic [11:0] d);
    chk("bmp_rdy_blank", 16'(bmp_ready), 16'd1);
    bmp_addr = 8'(a); bmp_data = d; bmp_valid = 1'b1;
    step(479, 0, 1'b1, "wr");
    bmp_valid = 1'b0;
    m_ram[a] = d; m_known[a] = 1'b1;
  endtask

  // Sampled frame; hook_kind 1 = mid-frame position request, 2 = mid-frame bitmap request
  task automatic frame(input int rstep, input int cstep, input int hook_row, input int hook_kind);
    bit first, pend_pos, pend_bmp;
    first = 1'b1; pend_pos = 1'b0; pend_bmp = 1'b0;
    repeat (4) step(0, 0, 1'b1, "idle");
    for (int r = 0; r < 480; r++) begin
      if (!row_sel(r, rstep)) continue;
      if (r == hook_row && hook_kind == 1) begin
        chk("pos_rdy_mid", 16'(pos_ready), 16'd1);
        pos_x = 10'd300; pos_y = 9'd300; pos_flip = 1'b0; pos_valid = 1'b1;
        step(r, 0, 1'b1, "hook");
        pos_valid = 1'b0;
        p_x = 300; p_y = 300; p_flip = 1'b0; pend_pos = 1'b1;
      end
      if (r == hook_row && hook_kind == 2) begin
        bmp_addr = 8'h01; bmp_data = 12'h456; bmp_valid = 1'b1; pend_bmp = 1'b1;
      end
      for (int c = 0; c < 640; c++) begin
        if (!col_sel(c, cstep)) continue;
        step(r, c, 1'b0, "px");
        if (first) begin
          first = 1'b0;
          chk("vblank_clr", 16'(vblank), 16'd0);
        end
      end
      if (pend_pos) chk("pos_rdy_held", 16'(pos_ready), 16'd0);
      if (pend_bmp) chk("bmp_rdy_stall", 16'(bmp_ready), 16'd0);
      step(r, 0, 1'b1, "gap");
    end
    m_frame = m_frame + 16'd1;
    chk("vblank_set", 16'(vblank), 16'd1);
    chk("frame_cnt", frame_cnt, m_frame);
    chk("bmp_rdy_vb", 16'(bmp_ready), 16'd1);
    if (pend_pos) begin
      m_x = p_x; m_y = p_y; m_flip = p_flip;
    end
    if (pend_bmp) begin
      step(479, 0, 1'b1, "wr");
      bmp_valid = 1'b0;
      m_ram[1] = 12'h456; m_known[1] = 1'b1;
    end
    repeat (4) step(479, 0, 1'b1, "idle");
    chk("pos_rdy_end", 16'(pos_ready), 16'd1);
  endtask

  initial begin
    logic [11:0] v;
    bit          known;
    clrn = 1'b0; rdn = 1'b1; row_addr = 9'd0; col_addr = 10'd0;
    pos_x = 10'd0; pos_y = 9'd0; pos_flip = 1'b0; pos_valid = 1'b0;
    bmp_addr = 8'd0; bmp_data = 12'd0; bmp_valid = 1'b0;
    m_x = 0; m_y = 0; m_flip = 1'b0; p_x = 0; p_y = 0; p_flip = 1'b0; m_frame = 16'd0;
    for (int i = 0; i < 256; i++) begin m_ram[i] = 12'h000; m_known[i] = 1'b0; end

    // Reset values
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_d_in", 16'(d_in), 16'd0);
    chk("rst_pos_ready", 16'(pos_ready), 16'd0);
    chk("rst_bmp_ready", 16'(bmp_ready), 16'd0);
    chk("rst_vblank", 16'(vblank), 16'd1);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    clrn = 1'b1;

    // 1: background frame, nothing written yet
    frame(16, 16, -1, 0);

    // 2: single opaque pixel at bitmap origin, sprite at (100,50)
    for (int i = 0; i < 256; i++) wr_bmp(i, (i == 0) ? 12'h00F : 12'hF0F);
    req_pos(100, 50, 1'b0);
    rows_q = '{50, 51};
    cols_q = '{99, 100, 101, 115, 116};
    frame(60, 80, -1, 0);

    // 3: mirrored
    req_pos(100, 50, 1'b1);
    frame(60, 80, -1, 0);

    // 4: mid-frame request only takes effect from the following frame
    rows_q = '{200, 300};
    cols_q = '{300, 301, 315};
    frame(60, 80, 200, 1);
    frame(60, 80, -1, 0);

    // 5: bitmap write stalls until blank, then lands
    rows_q = '{10, 300};
    frame(60, 80, 10, 2);
    frame(60, 80, -1, 0);

    // 6: sprite hanging off the bottom-right corner; no wrap to row/col 0
    req_pos(630, 470, 1'b0);
    wr_bmp(8'h99, 12'h123);
    rows_q = '{0, 470, 471, 479};
    cols_q = '{0, 1, 630, 631, 639};
    frame(60, 80, -1, 0);

    // Reset asserted in the middle of a line
    step(470, 0, 1'b1, "idle");
    row_addr = 9'd470; col_addr = 10'd630; rdn = 1'b0;
    #1;
    known = exp_px(470, 630, v);
    if (known) chk("pre_rst_px", 16'(d_in), 16'(v));
    clrn = 1'b0;
    #1;
    chk("mid_rst_d_in", 16'(d_in), 16'd0);
    chk("mid_rst_vblank", 16'(vblank), 16'd1);
    chk("mid_rst_frame_cnt", frame_cnt, 16'd0);
    chk("mid_rst_pos_ready", 16'(pos_ready), 16'd0);
    chk("mid_rst_bmp_ready", 16'(bmp_ready), 16'd0);
    @(posedge vga_clk);
    #1;
    rdn = 1'b1;
    @(posedge vga_clk);
    #1;
    clrn = 1'b1;
    m_x = 0; m_y = 0; m_flip = 1'b0; m_frame = 16'd0;
    rows_q = '{0, 1};
    cols_q = '{0, 1, 2};
    frame(240, 320, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
